zpu_sd_bridge: RTL and testbench

Bridges the ZPU firmware's register window to the HPS sector-transfer interface for cartridge and image access. It sits between the hps_io SD/mount signals and the atari5200top ZPU ports. It owns a 512-byte sector buffer, a byte pointer, LBA capture, the block read/write request handshake and the mount/status reporting. The ZPU polls it to load cartridges and images.

---
 rtl/zpu_sd_pkg.sv | 27 ++
 rtl/sector_dpram.sv | 34 +++
 rtl/zpu_sd_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_zpu_sd_bridge.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zpu_sd_pkg.sv
// Shared constants and types for the ZPU <-> HPS sector bridge.
// Optional block-write path is enabled by defining ZPU_SD_WRITE_EN.
package zpu_sd_pkg;

    localparam int BUF_AW_DEF = 9;

    localparam int OUT2_LBA_SEL  = 0;
    localparam int OUT2_BLOCK_RD = 1;
    localparam int OUT2_BLOCK_WR = 2;

    localparam int RD_DATA   = 2;
    localparam int WR_IO_RST = 5;
    localparam int WR_DATA   = 6;

    localparam int IN2_IO_DONE  = 0;
    localparam int IN2_MOUNTED  = 1;
    localparam int IN2_FILENO   = 2;
    localparam int IN2_FILETYPE = 5;
    localparam int IN2_READONLY = 7;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER
    } xfer_state_t;

endpackage

// File: rtl/sector_dpram.sv
// Generic true dual-port RAM with registered read data on both ports.
// Port A write wins over port B when both hit the same address.
module sector_dpram #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic [AW-1:0] i_addr_a,
    input  logic [DW-1:0] i_din_a,
    input  logic          i_we_a,
    output logic [DW-1:0] o_q_a,
    input  logic [AW-1:0] i_addr_b,
    input  logic [DW-1:0] i_din_b,
    input  logic          i_we_b,
    output logic [DW-1:0] o_q_b
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_q_a;
    logic [DW-1:0] r_q_b;

    always_ff @(posedge i_clk) begin
        if (i_we_b)
            r_mem[i_addr_b] <= i_din_b;
        if (i_we_a)
            r_mem[i_addr_a] <= i_din_a;
        r_q_a <= r_mem[i_addr_a];
        r_q_b <= r_mem[i_addr_b];
    end

    assign o_q_a = r_q_a;
    assign o_q_b = r_q_b;

endmodule

// File: rtl/zpu_sd_bridge.sv
// ZPU register window to HPS sector transfer bridge.
// Define ZPU_SD_WRITE_EN to enable block writes and a writable mount.
module zpu_sd_bridge
    import zpu_sd_pkg::*;
#(
    parameter int BUF_AW = BUF_AW_DEF
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CORE_RESET,
    input  logic [31:0]       ZPU_OUT2,
    input  logic [31:0]       ZPU_OUT3,
    input  logic [15:0]       ZPU_RD,
    input  logic [15:0]       ZPU_WR,
    output logic [7:0]        ZPU_IN2,
    output logic [31:0]       ZPU_IN3,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic [BUF_AW-1:0] sd_buff_addr,
    input  logic [7:0]        sd_buff_dout,
    input  logic              sd_buff_wr,
    output logic [7:0]        sd_buff_din,
    input  logic              img_mounted,
    input  logic [63:0]       img_size,
    input  logic [7:0]        ioctl_index
);

    logic              r_wr_d1, r_wr_d2, r_bwe, r_rd_d;
    logic [BUF_AW-1:0] r_ptr;
    logic [31:0]       r_lba;
    logic              r_brd_d, r_ack_d, r_mnt_d;
    xfer_state_t       r_state, w_state_nx;
    logic              r_sd_rd, r_sd_wr, r_io_done;
    logic              w_rd_nx, w_wr_nx, w_done_nx;
    logic              r_mounted;
    logic [2:0]        r_fileno;
    logic [1:0]        r_filetype;
    logic [31:0]       r_filesize;
    logic              w_readonly;
    logic [7:0]        w_buf_q;
    logic [7:0]        w_in2;

    logic w_wr_rise, w_rd_fall, w_brd_rise, w_bwr_rise;
    logic w_ack_fall, w_mnt_rise, w_lba_sel;

    assign w_lba_sel  = ZPU_OUT2[OUT2_LBA_SEL];
    assign w_wr_rise  = r_wr_d1 & ~r_wr_d2;
    assign w_rd_fall  = r_rd_d & ~ZPU_RD[RD_DATA];
    assign w_brd_rise = ZPU_OUT2[OUT2_BLOCK_RD] & ~r_brd_d;
    assign w_ack_fall = r_ack_d & ~sd_ack;
    assign w_mnt_rise = img_mounted & ~r_mnt_d;

`ifdef ZPU_SD_WRITE_EN
    logic r_bwr_d;
    logic r_readonly;

    assign w_bwr_rise = ZPU_OUT2[OUT2_BLOCK_WR] & ~r_bwr_d;
    assign w_readonly = r_readonly;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_bwr_d    <= 1'b0;
            r_readonly <= 1'b1;
        end else begin
            r_bwr_d <= ZPU_OUT2[OUT2_BLOCK_WR];
            if (!CORE_RESET && w_mnt_rise)
                r_readonly <= 1'b0;
        end
    end
`else
    logic w_unused_wr;

    assign w_bwr_rise  = 1'b0;
    assign w_readonly  = 1'b1;
    assign w_unused_wr = ZPU_OUT2[OUT2_BLOCK_WR];
`endif

    // Data strobe is resynchronised; ZPU reads advance on the strobe's falling edge
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_d1 <= 1'b0;
            r_wr_d2 <= 1'b0;
            r_bwe   <= 1'b0;
            r_rd_d  <= 1'b0;
            r_ptr   <= '0;
            r_lba   <= '0;
        end else begin
            r_wr_d1 <= ZPU_WR[WR_DATA];
            r_wr_d2 <= r_wr_d1;
            r_rd_d  <= ZPU_RD[RD_DATA];
            r_bwe   <= w_wr_rise & ~w_lba_sel;
            if (w_wr_rise && w_lba_sel)
                r_lba <= ZPU_OUT3;
            if (ZPU_WR[WR_IO_RST])
                r_ptr <= '0;
            else if (r_bwe || w_rd_fall)
                r_ptr <= r_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= IDLE;
            r_sd_rd   <= 1'b0;
            r_sd_wr   <= 1'b0;
            r_io_done <= 1'b0;
            r_brd_d   <= 1'b0;
            r_ack_d   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_sd_rd   <= w_rd_nx;
            r_sd_wr   <= w_wr_nx;
            r_io_done <= w_done_nx;
            r_brd_d   <= ZPU_OUT2[OUT2_BLOCK_RD];
            r_ack_d   <= sd_ack;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_rd_nx    = r_sd_rd;
        w_wr_nx    = r_sd_wr;
        w_done_nx  = r_io_done;
        unique case (r_state)
            IDLE: begin
                if (w_brd_rise) begin
                    w_rd_nx    = 1'b1;
                    w_done_nx  = 1'b0;
                    w_state_nx = REQ;
                end else if (w_bwr_rise) begin
                    w_wr_nx    = 1'b1;
                    w_done_nx  = 1'b0;
                    w_state_nx = REQ;
                end
            end
            REQ: begin
                if (sd_ack) begin
                    w_rd_nx    = 1'b0;
                    w_wr_nx    = 1'b0;
                    w_state_nx = XFER;
                end
            end
            XFER: begin
                if (w_ack_fall) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Soft reset re-derives mounted from the current image size
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_mnt_d    <= 1'b0;
            r_mounted  <= 1'b0;
            r_fileno   <= '0;
            r_filetype <= '0;
            r_filesize <= '0;
        end else begin
            r_mnt_d <= img_mounted;
            if (CORE_RESET) begin
                r_mounted <= |img_size[31:0];
            end else if (w_mnt_rise) begin
                r_fileno   <= '0;
                r_filetype <= ioctl_index[7:6];
                r_filesize <= img_size[31:0];
                r_mounted  <= ~r_mounted;
            end
        end
    end

    sector_dpram #(
        .AW(BUF_AW),
        .DW(8)
    ) u_buf (
        .i_clk   (CLK),
        .i_addr_a(sd_buff_addr),
        .i_din_a (sd_buff_dout),
        .i_we_a  (sd_buff_wr),
        .o_q_a   (sd_buff_din),
        .i_addr_b(r_ptr),
        .i_din_b (ZPU_OUT3[7:0]),
        .i_we_b  (r_bwe),
        .o_q_b   (w_buf_q)
    );

    always_comb begin
        w_in2                     = '0;
        w_in2[IN2_IO_DONE]        = r_io_done;
        w_in2[IN2_MOUNTED]        = r_mounted;
        w_in2[IN2_FILENO +: 3]    = r_fileno;
        w_in2[IN2_FILETYPE +: 2]  = r_filetype;
        w_in2[IN2_READONLY]       = w_readonly;
    end

    assign ZPU_IN2 = w_in2;
    assign ZPU_IN3 = w_lba_sel ? r_filesize : {24'b0, w_buf_q};
    assign sd_lba  = r_lba;
    assign sd_rd   = r_sd_rd;
    assign sd_wr   = r_sd_wr;

    logic w_unused;
    assign w_unused = &{1'b0, ZPU_OUT2[31:3], ZPU_RD[15:3], ZPU_RD[1:0],
                        ZPU_WR[15:7], ZPU_WR[4:0], img_size[63:32],
                        ioctl_index[5:0]};

endmodule

// File: tb/tb_zpu_sd_bridge.sv
// Scoreboard bench for zpu_sd_bridge; honours ZPU_SD_WRITE_EN.
module tb_zpu_sd_bridge;

`ifdef ZPU_SD_WRITE_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        CORE_RESET = 1'b0;
    logic [31:0] ZPU_OUT2 = '0;
    logic [31:0] ZPU_OUT3 = '0;
    logic [15:0] ZPU_RD = '0;
    logic [15:0] ZPU_WR = '0;
    logic [7:0]  ZPU_IN2;
    logic [31:0] ZPU_IN3;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack = 1'b0;
    logic [8:0]  sd_buff_addr = '0;
    logic [7:0]  sd_buff_dout = '0;
    logic        sd_buff_wr = 1'b0;
    logic [7:0]  sd_buff_din;
    logic        img_mounted = 1'b0;
    logic [63:0] img_size = '0;
    logic [7:0]  ioctl_index = '0;

    zpu_sd_bridge #(.BUF_AW(9)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CORE_RESET(CORE_RESET),
        .ZPU_OUT2(ZPU_OUT2), .ZPU_OUT3(ZPU_OUT3),
        .ZPU_RD(ZPU_RD), .ZPU_WR(ZPU_WR),
        .ZPU_IN2(ZPU_IN2), .ZPU_IN3(ZPU_IN3),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .img_mounted(img_mounted), .img_size(img_size),
        .ioctl_index(ioctl_index)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       nm;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_run = 0;
    int   n_fail = 0;

    function automatic logic [31:0] probe(int sel);
        case (sel)
            0: return sd_lba;
            1: return {31'b0, sd_rd};
            2: return {31'b0, sd_wr};
            3: return {24'b0, ZPU_IN2};
            4: return ZPU_IN3;
            5: return {24'b0, sd_buff_din};
            6: return {31'b0, ZPU_IN2[0]};
            default: return {31'b0, ZPU_IN2[1]};
        endcase
    endfunction

    // Monitor: drains every pending expectation at the falling edge
    always @(negedge CLK) begin
        while (q.size() > 0) begin
            chk_t c;
            logic [31:0] got;
            c = q.pop_front();
            got = probe(c.sel);
            n_run++;
            if (got !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", c.nm, got, c.exp);
            end
        end
    end

    task automatic expect_v(string nm, int sel, logic [31:0] exp);
        chk_t c;
        c.nm = nm;
        c.sel = sel;
        c.exp = exp;
        q.push_back(c);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic zwrite(logic [31:0] v);
        ZPU_OUT3 = v;
        ZPU_WR[6] = 1'b1;
        tick();
        tick();
        ZPU_WR[6] = 1'b0;
        repeat (3) tick();
    endtask

    logic [7:0] ro;

    initial begin
        ro = WEN ? 8'h00 : 8'h80;

        repeat (3) tick();
        expect_v("rst_lba", 0, 32'h0);
        expect_v("rst_rd", 1, 32'h0);
        expect_v("rst_wr", 2, 32'h0);
        expect_v("rst_in2", 3, 32'h80);
        tick();
        RESET_N = 1'b1;
        tick();

        sd_buff_addr = 9'd3;
        sd_buff_dout = 8'hA5;
        sd_buff_wr = 1'b1;
        tick();
        sd_buff_wr = 1'b0;
        ZPU_WR[5] = 1'b1;
        tick();
        ZPU_WR[5] = 1'b0;
        tick();
        zwrite(32'h11);
        zwrite(32'h22);
        zwrite(32'h33);
        for (int i = 0; i < 3; i++) begin
            sd_buff_addr = 9'(i);
            tick();
            expect_v("hps_rd", 5, 32'h11 * (i + 1));
        end
        expect_v("ptr_at_3", 4, 32'hA5);
        tick();

        ZPU_OUT2 = 32'h1;
        zwrite(32'h0000_1234);
        expect_v("lba_load", 0, 32'h1234);
        tick();
        ZPU_OUT2 = 32'h2;
        expect_v("rd_pre", 1, 32'h0);
        tick();
        expect_v("rd_req", 1, 32'h1);
        expect_v("done_clr", 6, 32'h0);
        sd_ack = 1'b1;
        expect_v("rd_hold", 1, 32'h1);
        tick();
        expect_v("rd_drop", 1, 32'h0);
        repeat (9) tick();
        sd_ack = 1'b0;
        expect_v("done_wait", 6, 32'h0);
        tick();
        expect_v("done_set", 6, 32'h1);
        ZPU_OUT2 = 32'h0;
        tick();

        for (int i = 0; i < 512; i++) begin
            sd_buff_addr = 9'(i);
            sd_buff_dout = 8'(i);
            sd_buff_wr = 1'b1;
            tick();
        end
        sd_buff_wr = 1'b0;
        ZPU_WR[5] = 1'b1;
        tick();
        ZPU_WR[5] = 1'b0;
        tick();
        tick();
        for (int k = 0; k <= 512; k++) begin
            expect_v("zpu_rd_seq", 4, 32'(k & 8'hFF));
            if (k < 512) begin
                ZPU_RD[2] = 1'b1;
                tick();
                ZPU_RD[2] = 1'b0;
                tick();
                tick();
            end
        end
        tick();

        ioctl_index = 8'h40;
        img_size = 64'h8000;
        img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
        expect_v("mount_in2", 3, 32'(ro | 8'h23));
        ZPU_OUT2 = 32'h1;
        expect_v("filesize", 4, 32'h8000);
        tick();
        img_size = 64'h0;
        CORE_RESET = 1'b1;
        tick();
        CORE_RESET = 1'b0;
        expect_v("soft_rst_in2", 3, 32'(ro | 8'h21));
        expect_v("soft_rst_mnt", 7, 32'h0);
        ZPU_OUT2 = 32'h0;
        tick();

        ZPU_OUT2 = 32'h6;
        tick();
        expect_v("both_rd", 1, 32'h1);
        expect_v("both_wr", 2, 32'h0);
        sd_ack = 1'b1;
        tick();
        tick();
        sd_ack = 1'b0;
        tick();
        tick();
        ZPU_OUT2 = 32'h0;
        tick();
        ZPU_OUT2 = 32'h4;
        tick();
        expect_v("bwr_wr", 2, 32'(WEN));
        expect_v("bwr_rd", 1, 32'h0);
        expect_v("bwr_done", 6, 32'(!WEN));
        sd_ack = 1'b1;
        tick();
        tick();
        sd_ack = 1'b0;
        tick();
        tick();
        expect_v("bwr_end", 2, 32'h0);

        ZPU_OUT2 = 32'h0;
        tick();
        ZPU_OUT2 = 32'h2;
        tick();
        sd_ack = 1'b1;
        tick();
        tick();
        RESET_N = 1'b0;
        sd_ack = 1'b0;
        ZPU_OUT2 = 32'h0;
        #1;
        expect_v("arst_lba", 0, 32'h0);
        expect_v("arst_rd", 1, 32'h0);
        expect_v("arst_wr", 2, 32'h0);
        expect_v("arst_in2", 3, 32'h80);
        tick();
        RESET_N = 1'b1;
        tick();
        ZPU_OUT2 = 32'h2;
        expect_v("post_rst_rd0", 1, 32'h0);
        tick();
        expect_v("post_rst_rd1", 1, 32'h1);

        repeat (3) tick();
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
